// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types, constants and byte-merge helper for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_MERGE_WR, S_NOP} state_t;
  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;
  localparam logic [3:0] WSTRB_FULL = 4'hF;
  function automatic logic [31:0] merge_bytes(input logic [31:0] wdata, input logic [3:0] wstrb,
                                              input logic [31:0] old);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wstrb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
    return w;
  endfunction
endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2: combinational 2-way round-robin grant picker
// Ports: i_req[1:0] requests, i_last_gnt id granted last, i_enable allow a grant, o_gnt[1:0] one-hot grant
module mem_arb_rr2 import mem_arb_pkg::*; (
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  input  logic       i_enable,
  output logic [1:0] o_gnt
);
  assign o_gnt = !i_enable ? 2'b00 : (&i_req) ? ((i_last_gnt == M1_ID) ? 2'b01 : 2'b10) : i_req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of a single-port word memory between two masters, with RMW byte writes
// Ports: clk/reset (sync, active high); per master mX_req/we/addr/wdata/wstrb in, mX_gnt/done/rdata out;
//        memory side mem_address/mem_data_out/mem_we out, mem_data_in in (valid READ_LAT cycles after address)
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int READ_LAT = 1,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  output logic        mem_we,
  input  logic [31:0] mem_data_in
);
  state_t            r_state, w_next;
  logic              r_last_gnt, r_id, r_we, r_m0_done, r_m1_done;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_mem_addr, r_wdata, r_m0_rdata, r_m1_rdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        w_gnt;
  logic              w_gnt_any, w_sel, w_we, w_enable, w_rd_sample, w_finish;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_addr, w_wdata;

  mem_arb_rr2 u_rr (
    .i_req      ({m1_req, m0_req}),
    .i_last_gnt (r_last_gnt),
    .i_enable   (w_enable),
    .o_gnt      (w_gnt)
  );

  assign w_gnt_any   = |w_gnt;
  assign w_sel       = w_gnt[1];
  assign w_we        = w_sel ? m1_we    : m0_we;
  assign w_wstrb     = w_sel ? m1_wstrb : m0_wstrb;
  assign w_addr      = w_sel ? m1_addr  : m0_addr;
  assign w_wdata     = w_sel ? m1_wdata : m0_wdata;
  assign w_rd_sample = (r_state == S_RD) && (r_cnt == '0);
  assign w_finish    = (w_rd_sample && !r_we) || (r_state inside {S_WR, S_MERGE_WR, S_NOP});

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Partial writes take the RD path first to fetch the word they merge into.
  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE && w_gnt_any)
      w_next = (!w_we || (w_wstrb != WSTRB_FULL && w_wstrb != '0)) ? S_RD :
               (w_wstrb == WSTRB_FULL) ? S_WR : S_NOP;
    else if (r_state == S_RD)
      w_next = (r_cnt != '0) ? S_RD : r_we ? S_MERGE_WR : S_IDLE;
    else if (r_state inside {S_WR, S_MERGE_WR, S_NOP})
      w_next = S_IDLE;
  end

  always_comb begin
    w_enable     = (r_state == S_IDLE) && !reset;
    m0_gnt       = w_gnt[0];
    m1_gnt       = w_gnt[1];
    mem_we       = r_state inside {S_WR, S_MERGE_WR};
    mem_address  = r_mem_addr;
    mem_data_out = r_wdata;
    m0_done      = r_m0_done;
    m1_done      = r_m1_done;
    m0_rdata     = r_m0_rdata;
    m1_rdata     = r_m1_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt <= M1_ID;
      r_id       <= M0_ID;
      r_we       <= 1'b0;
      r_wstrb    <= '0;
      r_wdata    <= '0;
      r_mem_addr <= '0;
      r_cnt      <= '0;
      r_m0_done  <= 1'b0;
      r_m1_done  <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_m0_done <= w_finish && (r_id == M0_ID);
      r_m1_done <= w_finish && (r_id == M1_ID);
      if (r_state == S_RD) r_cnt <= r_cnt - 1'b1;
      if (w_gnt_any) begin
        r_id       <= w_sel;
        r_last_gnt <= w_sel;
        r_we       <= w_we;
        r_wstrb    <= w_wstrb;
        r_wdata    <= w_wdata;
        r_cnt      <= CNT_W'(READ_LAT);
        // An empty-strobe write never touches memory, so the bus address is left alone.
        if (!(w_we && w_wstrb == '0)) r_mem_addr <= w_addr & ~32'h3;
      end
      if (w_rd_sample) begin
        if (r_we)                r_wdata    <= merge_bytes(r_wdata, r_wstrb, mem_data_in);
        else if (r_id == M0_ID)  r_m0_rdata <= mem_data_in;
        else                     r_m1_rdata <= mem_data_in;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (READ_LAT 1 and 3 instances)
module tb_mem_port_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0] m0_wstrb = '0, m1_wstrb = '0;
  logic a_m0_gnt, a_m0_done, a_m1_gnt, a_m1_done, a_mem_we;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_mem_address, a_mem_data_out, a_mem_data_in;
  logic b_m0_gnt, b_m0_done, b_m1_gnt, b_m1_done, b_mem_we;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_mem_address, b_mem_data_out, b_mem_data_in;
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic pl_en = 0;
  logic [7:0] pl_idx = '0;
  logic [31:0] pl_val = '0;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.READ_LAT(1), .CNT_W(4)) u_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(a_m0_gnt), .m0_done(a_m0_done), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(a_m1_gnt), .m1_done(a_m1_done), .m1_rdata(a_m1_rdata),
    .mem_address(a_mem_address), .mem_data_out(a_mem_data_out), .mem_we(a_mem_we),
    .mem_data_in(a_mem_data_in)
  );

  mem_port_arbiter #(.READ_LAT(3), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(b_m0_gnt), .m0_done(b_m0_done), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(b_m1_gnt), .m1_done(b_m1_done), .m1_rdata(b_m1_rdata),
    .mem_address(b_mem_address), .mem_data_out(b_mem_data_out), .mem_we(b_mem_we),
    .mem_data_in(b_mem_data_in)
  );

  assign a_mem_data_in = mem_a[a_mem_address[9:2]];
  assign b_mem_data_in = mem_b[b_mem_address[9:2]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem_a[pl_idx] <= pl_val;
      mem_b[pl_idx] <= pl_val;
    end
    if (a_mem_we) mem_a[a_mem_address[9:2]] <= a_mem_data_out;
    if (b_mem_we) mem_b[b_mem_address[9:2]] <= b_mem_data_out;
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    m0_req = 1; m1_req = 1; m0_we = 1; m0_wstrb = 4'hF;
    @(posedge clk); @(posedge clk); #1; #1;
    n_tests++;
    if ({a_m0_gnt, a_m1_gnt, a_m0_done, a_m1_done, a_mem_we} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 00000", {a_m0_gnt, a_m1_gnt, a_m0_done, a_m1_done, a_mem_we});
    end
    n_tests++;
    if ({a_mem_address, a_mem_data_out, a_m0_rdata, a_m1_rdata} !== 128'b0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h %h exp zeros", a_mem_address, a_mem_data_out, a_m0_rdata, a_m1_rdata);
    end
    m0_req = 0; m1_req = 0; m0_we = 0; m0_wstrb = 0; reset = 0;
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h104; #1;
    n_tests++;
    if ({a_m0_gnt, a_m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL read_gnt got %b exp 10", {a_m0_gnt, a_m1_gnt}); end
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1; m0_req = 0; #1;
      n_tests++;
      if (a_mem_we !== 1'b0) begin n_fail++; $display("FAIL read_we c%0d got %b exp 0", c, a_mem_we); end
      if (c <= 2) begin
        n_tests++;
        if (a_mem_address !== 32'h104) begin n_fail++; $display("FAIL read_addr c%0d got %h exp 00000104", c, a_mem_address); end
      end
      n_tests++;
      if (a_m0_done !== 1'(c == 3)) begin n_fail++; $display("FAIL read_done c%0d got %b exp %b", c, a_m0_done, c == 3); end
      if (c == 3) begin
        n_tests++;
        if (a_m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data got %h exp deadbeef", a_m0_rdata); end
      end
    end
  endtask

  task automatic test_full_write();
    @(posedge clk); #1;
    m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h12345678; m1_wstrb = 4'hF; #1;
    n_tests++;
    if ({a_m0_gnt, a_m1_gnt} !== 2'b01) begin n_fail++; $display("FAIL fw_gnt got %b exp 01", {a_m0_gnt, a_m1_gnt}); end
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1; m1_req = 0; #1;
      n_tests++;
      if (a_mem_we !== 1'(c == 1)) begin n_fail++; $display("FAIL fw_we c%0d got %b exp %b", c, a_mem_we, c == 1); end
      if (c == 1) begin
        n_tests++;
        if ({a_mem_address, a_mem_data_out} !== {32'h200, 32'h12345678}) begin
          n_fail++; $display("FAIL fw_bus got %h %h exp 00000200 12345678", a_mem_address, a_mem_data_out);
        end
      end
      n_tests++;
      if ({a_m0_done, a_m1_done} !== {1'b0, 1'(c == 2)}) begin
        n_fail++; $display("FAIL fw_done c%0d got %b exp 0%b", c, {a_m0_done, a_m1_done}, c == 2);
      end
    end
    n_tests++;
    if (mem_a[8'h80] !== 32'h12345678) begin n_fail++; $display("FAIL fw_mem got %h exp 12345678", mem_a[8'h80]); end
  endtask

  task automatic test_partial_write();
    preload(8'h80, 32'h11223344);
    @(posedge clk); #1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h202; m0_wdata = 32'h00AB0000; m0_wstrb = 4'b0100; #1;
    n_tests++;
    if (a_m0_gnt !== 1'b1) begin n_fail++; $display("FAIL pw_gnt got %b exp 1", a_m0_gnt); end
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1; m0_req = 0; #1;
      n_tests++;
      if (a_mem_we !== 1'(c == 3)) begin n_fail++; $display("FAIL pw_we c%0d got %b exp %b", c, a_mem_we, c == 3); end
      if (c <= 3) begin
        n_tests++;
        if (a_mem_address !== 32'h200) begin n_fail++; $display("FAIL pw_addr c%0d got %h exp 00000200", c, a_mem_address); end
      end
      if (c == 3) begin
        n_tests++;
        if (a_mem_data_out !== 32'h11AB3344) begin n_fail++; $display("FAIL pw_data got %h exp 11ab3344", a_mem_data_out); end
      end
      n_tests++;
      if (a_m0_done !== 1'(c == 4)) begin n_fail++; $display("FAIL pw_done c%0d got %b exp %b", c, a_m0_done, c == 4); end
    end
    m0_we = 0; m0_wstrb = 0;
  endtask

  task automatic test_nop_write();
    @(posedge clk); #1;
    m1_req = 1; m1_we = 1; m1_addr = 32'h300; m1_wdata = 32'hFFFFFFFF; m1_wstrb = 4'h0; #1;
    n_tests++;
    if (a_m1_gnt !== 1'b1) begin n_fail++; $display("FAIL nop_gnt got %b exp 1", a_m1_gnt); end
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1; m1_req = 0; #1;
      n_tests++;
      if ({a_mem_we, b_mem_we} !== 2'b00) begin n_fail++; $display("FAIL nop_we c%0d got %b exp 00", c, {a_mem_we, b_mem_we}); end
      n_tests++;
      if ({a_m1_done, b_m1_done} !== {2{1'(c == 2)}}) begin
        n_fail++; $display("FAIL nop_done c%0d got %b exp %b%b", c, {a_m1_done, b_m1_done}, c == 2, c == 2);
      end
    end
    m1_we = 0; m1_wstrb = 0;
  endtask

  task automatic test_read_lat3();
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m0_addr = 32'h104; #1;
    n_tests++;
    if (b_m0_gnt !== 1'b1) begin n_fail++; $display("FAIL lat3_gnt got %b exp 1", b_m0_gnt); end
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1; m0_req = 0; #1;
      if (c <= 4) begin
        n_tests++;
        if (b_mem_address !== 32'h104) begin n_fail++; $display("FAIL lat3_addr c%0d got %h exp 00000104", c, b_mem_address); end
      end
      n_tests++;
      if (b_m0_done !== 1'(c == 5)) begin n_fail++; $display("FAIL lat3_done c%0d got %b exp %b", c, b_m0_done, c == 5); end
      if (c == 5) begin
        n_tests++;
        if (b_m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lat3_data got %h exp deadbeef", b_m0_rdata); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int grants = 0, dones = 0;
    logic busy = 1'b0, owner = 1'b0;
    @(posedge clk); #1; reset = 1;
    @(posedge clk); #1; reset = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h104;
    m1_req = 1; m1_we = 0; m1_addr = 32'h200;
    for (int c = 0; c < 60 && dones < 6; c++) begin
      #1;
      if (a_m0_done || a_m1_done) begin
        n_tests++;
        if (!busy || {a_m1_done, a_m0_done} !== (owner ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL b2b_done c%0d got %b exp owner %0d", c, {a_m1_done, a_m0_done}, owner);
        end
        n_tests++;
        if ((owner ? a_m1_rdata : a_m0_rdata) !== (owner ? 32'h11AB3344 : 32'hDEADBEEF)) begin
          n_fail++; $display("FAIL b2b_data c%0d got %h", c, owner ? a_m1_rdata : a_m0_rdata);
        end
        busy = 0; dones++;
      end
      if (a_m0_gnt || a_m1_gnt) begin
        n_tests++;
        if (busy || {a_m1_gnt, a_m0_gnt} !== (grants[0] ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL b2b_gnt #%0d got %b exp %b busy %b", grants, {a_m1_gnt, a_m0_gnt}, grants[0] ? 2'b10 : 2'b01, busy);
        end
        owner = a_m1_gnt; busy = 1; grants++;
      end
      @(posedge clk); #1;
      if (grants >= 6) begin m0_req = 0; m1_req = 0; end
    end
    n_tests++;
    if (grants != 6 || dones != 6) begin n_fail++; $display("FAIL b2b_count got %0d/%0d exp 6/6", grants, dones); end
    m0_req = 0; m1_req = 0;
    repeat (24) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    m0_req = 1; m0_we = 1; m0_addr = 32'h300; m0_wdata = 32'h0000BEEF; m0_wstrb = 4'b0011; #1;
    n_tests++;
    if (a_m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_gnt got %b exp 1", a_m0_gnt); end
    @(posedge clk); #1; m0_req = 0; reset = 1;
    for (int c = 2; c <= 8; c++) begin
      @(posedge clk); #1; reset = 0; #1;
      n_tests++;
      if ({a_mem_we, a_m0_done, a_m1_done} !== 3'b000) begin
        n_fail++; $display("FAIL rm_quiet c%0d got %b exp 000", c, {a_mem_we, a_m0_done, a_m1_done});
      end
    end
    @(posedge clk); #1;
    m0_req = 1; m0_we = 0; m1_req = 1; m1_we = 0; #1;
    n_tests++;
    if ({a_m1_gnt, a_m0_gnt} !== 2'b01) begin n_fail++; $display("FAIL rm_next_gnt got %b exp 01", {a_m1_gnt, a_m0_gnt}); end
    @(posedge clk); #1; m0_req = 0; m1_req = 0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    preload(8'h41, 32'hDEADBEEF);
    test_read();
    test_full_write();
    test_partial_write();
    test_nop_write();
    test_read_lat3();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port word memory (address / data_out / data_in / we) between two requesters: M0 = core, M1 = loader/DMA engine.
- Round-robin arbitration with a req/gnt/done handshake per master.
- Fixed, parameterised read latency.
- Byte-strobe writes are performed internally as read-modify-write, so masters never build merged words themselves.

Parameters:
- READ_LAT, 1, cycles from first address cycle to valid mem_data_in (legal 1..15).
- CNT_W, 4, width of the latency counter (must hold READ_LAT).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  M0 request; held, with fields stable, until m0_gnt
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  32  byte address; bits [1:0] ignored
- m0_wdata  in  32  write data, lane-positioned
- m0_wstrb  in  4  byte enables for writes
- m0_gnt  out  1  request accepted this cycle
- m0_done  out  1  one-cycle completion pulse
- m0_rdata  out  32  read word, valid when m0_done on a read
- m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_gnt, m1_done, m1_rdata: identical for M1
- mem_address  out  32  word-aligned address, {addr[31:2], 2'b00}
- mem_data_out  out  32  write word
- mem_we  out  1  full-word write enable
- mem_data_in  in  32  read word, READ_LAT cycles after address first presented, address held

Behaviour:
- Reset values (reset high at any edge):
  - state = IDLE; all gnt, done, mem_we = 0.
  - rdata, mem_address, mem_data_out = 0.
  - last_gnt = 1, so M0 wins the first tie.
  - Any in-flight transaction is dropped: no done, no write issued afterwards.
- States: IDLE, RD, WR, MERGE_WR, NOP.
- IDLE:
  - Both requests high: grant the master != last_gnt. One request high: grant it.
  - mX_gnt is combinational, high in the acceptance cycle (call it cycle 0).
  - At that edge the arbiter latches addr/we/wdata/wstrb/id and updates last_gnt.
  - The master may change req and fields from cycle 1.
- Transition out of IDLE:
  - Read, or write with wstrb != 4'hF and != 0: go to RD, counter = READ_LAT.
  - Write with wstrb == 4'hF: go to WR.
  - Write with wstrb == 0: go to NOP.
- RD:
  - mem_address held; counter decrements each cycle.
  - Data is sampled in the cycle mem_data_in is valid (cycle 1+READ_LAT).
  - Plain read: rdata latched, done issued, go to IDLE.
  - Partial write: merged word latched, go to MERGE_WR. Merge rule: byte i = wstrb[i] ? wdata byte i : mem_data_in byte i.
- WR and MERGE_WR: one cycle with mem_we = 1 and the latched/merged word on mem_data_out; done issued, go to IDLE.
- NOP: no memory access; done issued, go to IDLE.
- done:
  - Registered; high in the cycle after the completing state, only toward the latched id.
  - That cycle is IDLE, so a new grant may coincide with done.
  - rdata holds its value until the next read completion for that master.
- Latency from gnt cycle 0:
  - full write: done at cycle 2
  - read: done at cycle 2+READ_LAT
  - partial write: done at cycle 3+READ_LAT
  - wstrb = 0: done at cycle 2
- Outside transactions mem_we = 0 and mem_address holds its last value.
- mem_we is never asserted in IDLE or RD.
- Requests arriving while busy are not granted; masters keep req high.
- At most one gnt per cycle; never two grants without an intervening done.
- Fairness: with both masters continuously requesting, grants alternate strictly M0, M1, M0 …

Decomposition:
- Package mem_arb_pkg:
  - state encoding constants
  - master-id constants M0_ID = 0, M1_ID = 1
  - WSTRB_FULL = 4'hF
  - byte-merge function (wdata, wstrb, old) returning the merged word
- One sub-module, mem_arb_rr2: a 2-input round-robin grant picker.
  - Inputs: req[1:0], last_gnt, enable.
  - Output: one-hot gnt[1:0].
  - Purely combinational; last_gnt stays in the parent.

Test Plan:
- Reset, then M0 reads 0x0000_0104 while memory word 0x104 = 0xDEADBEEF, READ_LAT = 1:
  - m0_gnt at cycle 0, mem_address = 0x104 in cycles 1–2, m0_done with m0_rdata = 0xDEADBEEF at cycle 3
  - mem_we never high
- M1 full write, addr 0x200, wdata 0x12345678, wstrb F → exactly one mem_we cycle (cycle 1) with data 0x12345678; m1_done at cycle 2.
- M0 partial write, addr 0x202, wdata 0x00AB0000, wstrb 4'b0100, old word 0x11223344 → one write of 0x11AB3344, preceded by a read; done at cycle 3+READ_LAT.
- Both req continuously after reset, 6 single-word reads:
  - grant order M0, M1, M0, M1, M0, M1
  - each done goes only to the owner; no overlapping transactions
- wstrb = 0 write → no mem_we, no memory read, done at cycle 2. Separately, READ_LAT = 3 read → done at cycle 5.
- reset asserted during MERGE_WR's preceding RD → no mem_we ever issued, no done, next grant goes to M0.
